cnt_sched: RTL

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cnt_sched.sv
// cnt_sched: three-requester scheduler for a loadable up/down counter.
// A winner is picked by round-robin (or with requester 0 given absolute priority
// when CNT_SCHED_PRIO_EN is defined). Its LOAD, or its UP/DOWN burst of len
// steps, is then driven onto the counter. Bursts stop at the counter bounds
// instead of wrapping.
module cnt_sched #(
    parameter int N  = 6,
    parameter int LW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           req,
    input  logic [5:0]           op,
    input  logic [3*(N+1)-1:0]   data,
    input  logic [3*LW-1:0]      len,
    input  logic [N:0]           q,
    output logic [2:0]           gnt,
    output logic [N:0]           d,
    output logic                 load,
    output logic                 countup,
    output logic                 countdown,
    output logic                 busy,
    output logic                 done,
    output logic                 sat
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]    OP_NOP  = 2'b00;
    localparam logic [1:0]    OP_LOAD = 2'b01;
    localparam logic [1:0]    OP_UP   = 2'b10;
    localparam logic [1:0]    OP_DOWN = 2'b11;
    localparam logic [N:0]    QMAX    = '1;
    localparam logic [LW-1:0] ONE     = 1;

    state_t        state, next_state;
    logic [1:0]    ptr;
    logic [1:0]    op_r;
    logic [LW-1:0] rem;
    logic [1:0]    win;
    logic          win_valid;
    logic          step;
    logic          bound;

    // Winner selection; the pointer names the first requester to be considered
    always_comb begin
        win       = 2'd0;
        win_valid = |req;
`ifdef CNT_SCHED_PRIO_EN
        if (req[0]) begin
            win = 2'd0;
        end else if (ptr == 2'd2) begin
            if (req[2])      win = 2'd2;
            else if (req[1]) win = 2'd1;
        end else begin
            if (req[1])      win = 2'd1;
            else if (req[2]) win = 2'd2;
        end
`else
        case (ptr)
            2'd1: begin
                if (req[1])      win = 2'd1;
                else if (req[2]) win = 2'd2;
                else if (req[0]) win = 2'd0;
            end
            2'd2: begin
                if (req[2])      win = 2'd2;
                else if (req[0]) win = 2'd0;
                else if (req[1]) win = 2'd1;
            end
            default: begin
                if (req[0])      win = 2'd0;
                else if (req[1]) win = 2'd1;
                else if (req[2]) win = 2'd2;
            end
        endcase
`endif
    end

    // Next-state and counter controls; a step is never issued at the bound
    always_comb begin
        next_state = state;
        load       = 1'b0;
        countup    = 1'b0;
        countdown  = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        step       = 1'b0;
        bound      = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) next_state = RUN;
            end
            RUN: begin
                case (op_r)
                    OP_LOAD: begin
                        load       = 1'b1;
                        next_state = DONE;
                    end
                    OP_UP, OP_DOWN: begin
                        if (rem == '0) begin
                            next_state = DONE;
                        end else if ((op_r == OP_UP && q != QMAX) ||
                                     (op_r == OP_DOWN && q != '0)) begin
                            step      = 1'b1;
                            countup   = (op_r == OP_UP);
                            countdown = (op_r == OP_DOWN);
                            if (rem == ONE) next_state = DONE;
                        end else begin
                            bound      = 1'b1;
                            next_state = DONE;
                        end
                    end
                    default: next_state = DONE;
                endcase
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; reset aborts any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Grant capture, remaining-step count and saturation flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr  <= 2'd0;
            gnt  <= 3'b000;
            d    <= '0;
            sat  <= 1'b0;
            op_r <= OP_NOP;
            rem  <= '0;
        end else begin
            gnt <= 3'b000;
            if (state == IDLE && win_valid) begin
                gnt  <= 3'b001 << win;
                op_r <= op[2*int'(win) +: 2];
                d    <= data[int'(win)*(N+1) +: (N+1)];
                rem  <= len[int'(win)*LW +: LW];
                ptr  <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            end
            if (state == RUN) begin
                if (step) rem <= rem - ONE;
                if (op_r == OP_UP || op_r == OP_DOWN) begin
                    if (rem == '0)                sat <= 1'b0;
                    else if (step && rem == ONE)  sat <= 1'b0;
                    else if (bound)               sat <= 1'b1;
                end else if (op_r == OP_NOP) begin
                    sat <= 1'b0;
                end
            end
        end
    end

endmodule
